// File: rtl/fifo_read_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream seen by fifo_read_ctrl.
interface fifo_read_ctrl_if #(
  parameter int unsigned FIFO_WIDTH = 16
);
  logic                  empty;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  // Controller side: drives the read request and the stream.
  modport master (
    input  empty, data_out, m_ready,
    output rd_en, m_data, m_valid
  );

  // FIFO/consumer side.
  modport slave (
    output empty, data_out, m_ready,
    input  rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: issues reads, absorbs the one-cycle read latency
// in a 2-entry skid buffer and presents words on a valid/ready stream.
module fifo_read_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_read_ctrl_if.master     bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  buf_state_e            buf_q, buf_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;
  logic                  rd_en;

  // Read request: only fetch when buffered + in-flight words, after this
  // cycle's pop, leave room for the word being requested.
  always_comb begin
    pop       = (buf_q != BUF_EMPTY) && bus.m_ready;
    push      = inflight_q;
    occupancy = {1'b0, buf_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en     = rst_n && enable && !bus.empty && (occupancy <= 3'd1);
  end

  // Skid buffer next-state, in-flight tracking and delivered-word counter.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_en;
    rd_count_d = rd_count_q;
    if (pop) begin
      rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    unique case (buf_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d = bus.data_out;
          buf_d  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = bus.data_out;
        end else if (push) begin
          tail_d = bus.data_out;
          buf_d  = BUF_TWO;
        end else if (pop) begin
          buf_d  = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = bus.data_out;
          end else begin
            buf_d  = BUF_ONE;
          end
        end
      end
      default: buf_d = BUF_EMPTY;
    endcase
  end

  // State registers; reset discards in-flight and buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= BUF_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      rd_count_q <= '0;
    end else begin
      buf_q      <= buf_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.m_valid = (buf_q != BUF_EMPTY);
  assign bus.m_data  = head_q;
  assign rd_count    = rd_count_q;
  assign busy        = inflight_q || (buf_q != BUF_EMPTY);

  // The read gating guarantees a full buffer is never pushed without a pop.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && (buf_q == BUF_TWO) && !pop)
  );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a small behavioural FIFO model.
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] rd_count;
  logic        busy;
  logic [3:0]  rd_count2;
  logic        busy2;

  fifo_read_ctrl_if #(.FIFO_WIDTH(16)) bus ();
  fifo_read_ctrl_if #(.FIFO_WIDTH(16)) bus2 ();

  fifo_read_ctrl #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus.master),
    .rd_count (rd_count),
    .busy     (busy)
  );

  // Narrow-counter instance streaming continuously, used for the wrap check.
  fifo_read_ctrl #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (1'b1),
    .bus      (bus2.master),
    .rd_count (rd_count2),
    .busy     (busy2)
  );

  assign bus2.empty    = 1'b0;
  assign bus2.data_out = 16'h0000;
  assign bus2.m_ready  = 1'b1;

  always #5 clk = ~clk;

  // FIFO model: storage with read/write pointers; read data appears after the edge.
  logic [15:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        take   = 1'b0;
  int          rd_acc = 0;

  assign bus.empty = (rd_ptr == wr_ptr);

  always @(negedge clk) take = bus.rd_en && !bus.empty;

  always @(posedge clk) begin
    if (take) begin
      bus.data_out <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      rd_acc       <= rd_acc + 1;
    end
  end

  // Stream collector: records every word that will pop at the next edge.
  logic [15:0] got_q [$];
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 16'(i);
      wr_ptr++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((rd_ptr != wr_ptr || busy) && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_got(input string tag, input logic [15:0] base, input int n);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_word%0d", tag, i), {16'd0, got_q[i]}, {16'd0, base + 16'(i)});
    end
  endtask

  int acc0;

  initial begin
    bus.data_out = 16'h0000;
    bus.m_ready  = 1'b0;
    rst_n        = 1'b0;
    enable       = 1'b1;

    // 1. Reset with a word available: no read request, all outputs clear.
    load(16'h0055, 1);
    repeat (3) tick();
    check_eq("rst_rd_en",    {31'd0, bus.rd_en},   32'd0);
    check_eq("rst_m_valid",  {31'd0, bus.m_valid}, 32'd0);
    check_eq("rst_m_data",   {16'd0, bus.m_data},  32'd0);
    check_eq("rst_rd_count", {16'd0, rd_count},    32'd0);
    check_eq("rst_busy",     {31'd0, busy},        32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_rd_en", {31'd0, bus.rd_en}, 32'd1);
    got_q.delete();
    bus.m_ready = 1'b1;
    wait_idle("t1");
    check_got("t1", 16'h0055, 1);
    check_eq("t1_rd_count", {16'd0, rd_count}, 32'd1);

    // 2. Streaming: 10 words, m_valid two clocks after the first read.
    load(16'h0001, 10);
    #1;
    check_eq("t2_rd_en0", {31'd0, bus.rd_en}, 32'd1);
    tick();
    check_eq("t2_valid_e1", {31'd0, bus.m_valid}, 32'd0);
    check_eq("t2_busy_e1",  {31'd0, busy},        32'd1);
    tick();
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("t2_valid%0d", k), {31'd0, bus.m_valid}, 32'd1);
      check_eq($sformatf("t2_data%0d", k),  {16'd0, bus.m_data},  32'(k + 1));
      tick();
    end
    check_eq("t2_valid_end", {31'd0, bus.m_valid}, 32'd0);
    check_eq("t2_busy_end",  {31'd0, busy},        32'd0);
    check_eq("t2_rd_count",  {16'd0, rd_count},    32'd11);

    // 3. Backpressure: only two reads while the consumer stalls.
    got_q.delete();
    bus.m_ready = 1'b0;
    acc0 = rd_acc;
    load(16'h0101, 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 1) begin
        check_eq($sformatf("t3_hold_data%0d", i), {16'd0, bus.m_data}, 32'h0101);
        check_eq($sformatf("t3_hold_vld%0d", i),  {31'd0, bus.m_valid}, 32'd1);
      end
    end
    check_eq("t3_reads",  rd_acc - acc0, 32'd2);
    check_eq("t3_rd_en",  {31'd0, bus.rd_en}, 32'd0);
    bus.m_ready = 1'b1;
    wait_idle("t3");
    check_got("t3", 16'h0101, 5);
    check_eq("t3_rd_count", {16'd0, rd_count}, 32'd16);

    // 4. Single word: read drops as the FIFO runs empty.
    got_q.delete();
    load(16'h00A5, 1);
    #1;
    check_eq("t4_rd_en0", {31'd0, bus.rd_en}, 32'd1);
    tick();
    check_eq("t4_rd_en1", {31'd0, bus.rd_en}, 32'd0);
    check_eq("t4_busy1",  {31'd0, busy},      32'd1);
    tick();
    check_eq("t4_valid", {31'd0, bus.m_valid}, 32'd1);
    check_eq("t4_data",  {16'd0, bus.m_data},  32'h00A5);
    tick();
    check_eq("t4_valid_end", {31'd0, bus.m_valid}, 32'd0);
    check_eq("t4_busy_end",  {31'd0, busy},        32'd0);
    check_eq("t4_rd_count",  {16'd0, rd_count},    32'd17);

    // 5. enable dropped after one accepted read: that word still arrives.
    got_q.delete();
    load(16'h0C01, 3);
    #1;
    check_eq("t5_rd_en0", {31'd0, bus.rd_en}, 32'd1);
    tick();
    enable = 1'b0;
    #1;
    check_eq("t5_rd_en_off", {31'd0, bus.rd_en}, 32'd0);
    tick();
    check_eq("t5_valid", {31'd0, bus.m_valid}, 32'd1);
    check_eq("t5_data",  {16'd0, bus.m_data},  32'h0C01);
    tick();
    check_eq("t5_valid_end", {31'd0, bus.m_valid}, 32'd0);
    check_eq("t5_busy_end",  {31'd0, busy},        32'd0);
    repeat (2) tick();
    check_eq("t5_rd_en_idle", {31'd0, bus.rd_en}, 32'd0);
    enable = 1'b1;
    #1;
    check_eq("t5_rd_en_on", {31'd0, bus.rd_en}, 32'd1);
    wait_idle("t5");
    check_got("t5", 16'h0C01, 3);
    check_eq("t5_rd_count", {16'd0, rd_count}, 32'd20);

    // 6. Asynchronous reset with a full buffer, then restart.
    got_q.delete();
    bus.m_ready = 1'b0;
    load(16'h0D01, 4);
    repeat (3) tick();
    check_eq("t6_valid_pre", {31'd0, bus.m_valid}, 32'd1);
    check_eq("t6_busy_pre",  {31'd0, busy},        32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid_rst", {31'd0, bus.m_valid}, 32'd0);
    check_eq("t6_busy_rst",  {31'd0, busy},        32'd0);
    check_eq("t6_count_rst", {16'd0, rd_count},    32'd0);
    check_eq("t6_rd_en_rst", {31'd0, bus.rd_en},   32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("t6_rd_en_rel", {31'd0, bus.rd_en}, 32'd1);
    bus.m_ready = 1'b1;
    wait_idle("t6");
    check_got("t6", 16'h0D03, 2);
    check_eq("t6_rd_count", {16'd0, rd_count}, 32'd2);

    // 7. Counter wrap on the narrow-counter instance.
    for (int i = 0; i < 40 && rd_count2 != 4'hF; i++) tick();
    check_eq("t7_count_max", {28'd0, rd_count2}, 32'hF);
    check_eq("t7_valid",     {31'd0, bus2.m_valid}, 32'd1);
    tick();
    check_eq("t7_count_wrap", {28'd0, rd_count2}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the synchronous FIFO. It drains words from the FIFO read port and presents them on a valid/ready stream to a downstream consumer. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so back-to-back reads sustain one word per clock. It also keeps a running count of delivered words for the scoreboard.

Parameters:
FIFO_WIDTH, 16, data width of FIFO words and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits new FIFO reads; does not stop the drain of data already fetched
empty  input  1  FIFO empty flag
data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read
rd_en  output  1  FIFO read request (combinational)
m_data  output  FIFO_WIDTH  stream data (head of skid buffer)
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
rd_count  output  CNT_WIDTH  number of words delivered (m_valid && m_ready), wraps modulo 2^CNT_WIDTH
busy  output  1  high while inflight=1 or buf_cnt>0

Behaviour:
- Reset (rst_n=0, async): buf_cnt=0, inflight=0, m_valid=0, m_data=0, rd_count=0, busy=0. rd_en is gated by rst_n and is 0 during reset. Reset mid-transfer discards in-flight and buffered words.
- FIFO contract: rd_en is sampled at posedge. When empty=0, data_out is updated at that edge. The block treats a read as accepted only if rd_en && !empty at the edge.
- inflight register: next = rd_en && !empty. When inflight=1, data_out is captured into the skid buffer at the next posedge.
- pop = m_valid && m_ready.
- Skid buffer: 2 entries (head, tail); buf_cnt states EMPTY(0), ONE(1), TWO(2).
  - push only: EMPTY->ONE (head=data_out); ONE->TWO (tail=data_out).
  - pop only: TWO->ONE (head=tail); ONE->EMPTY.
  - push+pop: in ONE, head=data_out and stay ONE. In TWO, head=tail, tail=data_out, stay TWO.
  - push in TWO without pop is impossible by construction. Flag it with an assertion; no RTL recovery is required.
- m_valid = (buf_cnt != 0); m_data = head. Both are registered, with no combinational path from data_out.
- rd_en = rst_n && enable && !empty && (buf_cnt + inflight - pop <= 1). This gives a combinational path from m_ready to rd_en.
- Throughput: with m_ready held at 1 and FIFO non-empty, one word is delivered per clock after a 2-cycle startup.
  - Cycle 0: rd_en=1.
  - Edge 1: inflight=1.
  - Edge 2: m_valid=1.
- Backpressure: with m_ready=0, at most 2 words are fetched (buf TWO, inflight 0), then rd_en=0. Order is strictly preserved.
- enable=0: no new reads. Any inflight word is still captured, and buffered words still drain.
- empty asserting mid-stream: rd_en drops the same cycle. Already-accepted words are delivered. There is no underflow read.
- rd_count increments by 1 on every posedge with pop=1 and wraps 0xFFFF->0x0000 at the default width.
- busy = inflight || (buf_cnt != 0).

Test Plan:
1. Reset: hold rst_n=0 with empty=0, enable=1 -> rd_en=0, m_valid=0, m_data=0, rd_count=0. Release rst_n -> rd_en=1 the same cycle.
2. Streaming: FIFO preloaded with 10 words 0x0001..0x000A, m_ready=1 -> first m_valid 2 clocks after the first rd_en. Then 10 consecutive valid cycles carry data 0x0001..0x000A in order. rd_count=10, then busy=0.
3. Backpressure: 5 words queued, m_ready=0 for 6 cycles -> exactly 2 reads accepted, rd_en=0 thereafter, m_data=first word held stable. Raise m_ready -> remaining 5 words delivered in order, no loss or duplication.
4. Empty boundary: FIFO holding 1 word (0x00A5), m_ready=1 -> one read accepted, rd_en=0 once empty=1, single beat 0x00A5 delivered, then m_valid=0.
5. enable toggle: drop enable the cycle after a read is accepted -> that word is still delivered, and no further rd_en until enable=1.
6. Async reset mid-operation: assert rst_n=0 between edges while buf_cnt=2 -> m_valid, busy and rd_count clear immediately without a clock edge. After release, the stream restarts from the FIFO's post-reset contents.
